core_mailbox: RTL and testbench

CORE_MAILBOX -- requirements
Module: core_mailbox

---
 rtl/core_mailbox.sv | 179 +++++++++++++++++
 tb/tb_core_mailbox.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/core_mailbox.sv
// core_mailbox
// Two-way mailbox between two cores on a single RIB slave port.
//   FIFO A carries core0 -> core1 (non-empty interrupt on irq_a_o).
//   FIFO B carries core1 -> core0 (non-empty interrupt on irq_b_o).
//
// Register map (addr_i[4:2]):
//   0 A_PUSH  (W: push data_i, R: 0)
//   1 A_HEAD  (R: oldest entry or 0, W: pop)
//   2 A_STAT  (R: {count[15:8], ovf[2], full[1], empty[0]}, W: clear ovf)
//   3 B_PUSH  4 B_HEAD  5 B_STAT  (same as A)
//   6 IRQ_EN  (bits [1:0]; only with CORE_MAILBOX_IRQ_EN)
//   7 reserved (reads 0, writes ignored)
//
// Ports:
//   clk      single clock, rising edge
//   rst      synchronous active-high reset
//   we_i     write strobe
//   addr_i   address (only [4:2] decoded)
//   data_i   write data
//   data_o   combinational read data
//   irq_a_o  registered FIFO A non-empty interrupt
//   irq_b_o  registered FIFO B non-empty interrupt
//
// Configuration macro: CORE_MAILBOX_IRQ_EN
//   defined   -> IRQ_EN register and registered interrupt outputs
//   undefined -> IRQ_EN reads 0, interrupts tied to 0
//
// Parameter DEPTH: entries per FIFO, power of two in 2..64.

module core_mailbox #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_a_o,
    output logic        irq_b_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] REG_IRQ_EN = 3'd6;

    logic [2:0] sel;
    assign sel = addr_i[4:2];

    // Address bits outside [4:2] are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

    logic [1:0]          empty;
    logic [1:0]          full;
    logic [1:0]          ovf;
    logic [1:0][CW-1:0]  count;
    logic [1:0][31:0]    head;
    logic [1:0][31:0]    stat;
    logic [1:0]          irq_en;

    // gi = 0 is FIFO A, gi = 1 is FIFO B; each owns three consecutive registers.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            localparam logic [2:0] PUSH_REG = (gi == 0) ? 3'd0 : 3'd3;
            localparam logic [2:0] HEAD_REG = (gi == 0) ? 3'd1 : 3'd4;
            localparam logic [2:0] STAT_REG = (gi == 0) ? 3'd2 : 3'd5;

            // Storage is read asynchronously: HEAD must be visible in the
            // same cycle as the address, so this maps to distributed RAM.
            logic [31:0]   mem [DEPTH];
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic          ovf_reg;

            logic push;
            logic pop;
            logic clr;
            logic is_full;
            logic is_empty;

            assign is_full  = (count_reg == CW'(DEPTH));
            assign is_empty = (count_reg == '0);
            assign push     = we_i && (sel == PUSH_REG);
            assign pop      = we_i && (sel == HEAD_REG);
            assign clr      = we_i && (sel == STAT_REG);

            // Storage is not reset; HEAD masks it to 0 while empty.
            always_ff @(posedge clk) begin
                if (!rst && push && !is_full) begin
                    mem[wr_ptr_reg] <= data_i;
                end
            end

            // Push and pop never coincide (single slave port), so count
            // only ever moves by one in one direction per edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    ovf_reg    <= 1'b0;
                end else begin
                    if (push) begin
                        if (is_full) begin
                            ovf_reg <= 1'b1;
                        end else begin
                            wr_ptr_reg <= wr_ptr_reg + PW'(1);
                            count_reg  <= count_reg + CW'(1);
                        end
                    end
                    if (pop && !is_empty) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                        count_reg  <= count_reg - CW'(1);
                    end
                    if (clr) begin
                        ovf_reg <= 1'b0;
                    end
                end
            end

            assign empty[gi] = is_empty;
            assign full[gi]  = is_full;
            assign ovf[gi]   = ovf_reg;
            assign count[gi] = count_reg;
            assign head[gi]  = is_empty ? 32'd0 : mem[rd_ptr_reg];
            assign stat[gi]  = {16'd0, 8'(count_reg), 5'd0, ovf_reg, is_full, is_empty};
        end
    endgenerate

`ifdef CORE_MAILBOX_IRQ_EN
    logic [1:0] irq_en_reg;
    logic       irq_a_reg;
    logic       irq_b_reg;

    // Interrupts are sampled from current state, so they trail the
    // causing push/pop/IRQ_EN write by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_reg <= 2'b00;
            irq_a_reg  <= 1'b0;
            irq_b_reg  <= 1'b0;
        end else begin
            if (we_i && (sel == REG_IRQ_EN)) begin
                irq_en_reg <= data_i[1:0];
            end
            irq_a_reg <= irq_en_reg[0] & ~empty[0];
            irq_b_reg <= irq_en_reg[1] & ~empty[1];
        end
    end

    assign irq_en  = irq_en_reg;
    assign irq_a_o = irq_a_reg;
    assign irq_b_o = irq_b_reg;
`else
    assign irq_en  = 2'b00;
    assign irq_a_o = 1'b0;
    assign irq_b_o = 1'b0;
`endif

    // full/count are exposed through stat; kept as named nets for readability.
    logic unused_stat;
    assign unused_stat = ^{full, ovf, count};

    always_comb begin
        data_o = 32'd0;
        case (sel)
            3'd1:       data_o = head[0];
            3'd2:       data_o = stat[0];
            3'd4:       data_o = head[1];
            3'd5:       data_o = stat[1];
            REG_IRQ_EN: data_o = {30'd0, irq_en};
            default:    data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_core_mailbox.sv
// tb_core_mailbox
// Directed self-checking bench for core_mailbox (DEPTH = 8).
// Covers reset state, push/pop ordering, full/overflow, ovf clear,
// pointer wrap, pop on empty, mid-stream reset and interrupt timing
// (interrupt checks follow CORE_MAILBOX_IRQ_EN).

module tb_core_mailbox;

    localparam logic [2:0] A_PUSH = 3'd0;
    localparam logic [2:0] A_HEAD = 3'd1;
    localparam logic [2:0] A_STAT = 3'd2;
    localparam logic [2:0] B_PUSH = 3'd3;
    localparam logic [2:0] B_HEAD = 3'd4;
    localparam logic [2:0] B_STAT = 3'd5;
    localparam logic [2:0] IRQ_EN = 3'd6;
    localparam logic [2:0] RSVD   = 3'd7;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        irq_a_o;
    logic        irq_b_o;

    int checks_total;
    int checks_passed;

    core_mailbox #(.DEPTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .irq_a_o (irq_a_o),
        .irq_b_o (irq_b_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("check %-14s got=0x%08h exp=0x%08h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One write transaction: drive, take one rising edge, release 1 ns later.
    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        we_i   = 1'b1;
        addr_i = {27'd0, r, 2'b00};
        data_i = d;
        @(posedge clk);
        #1;
        we_i   = 1'b0;
        data_i = 32'd0;
    endtask

    // Combinational read: set the address, let it settle, compare.
    task automatic rd(input string tag, input logic [2:0] r, input logic [31:0] exp);
        we_i   = 1'b0;
        addr_i = {27'd0, r, 2'b00};
        #1;
        check(tag, data_o, exp);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        we_i   = 1'b0;
        addr_i = 32'd0;
        data_i = 32'd0;

        // Reset with a simultaneous push: reset must win.
        rst    = 1'b1;
        we_i   = 1'b1;
        addr_i = {27'd0, A_PUSH, 2'b00};
        data_i = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        we_i = 1'b0;

        rd("rst_a_stat", A_STAT, 32'h0000_0001);
        rd("rst_b_stat", B_STAT, 32'h0000_0001);
        rd("rst_a_head", A_HEAD, 32'h0000_0000);
        check("rst_irq_a", {31'd0, irq_a_o}, 32'd0);
        check("rst_irq_b", {31'd0, irq_b_o}, 32'd0);

        // Basic ordering on A.
        wr(A_PUSH, 32'h11);
        wr(A_PUSH, 32'h22);
        wr(A_PUSH, 32'h33);
        rd("a3_stat", A_STAT, 32'h0000_0300);
        rd("a3_head", A_HEAD, 32'h0000_0011);
        rd("a_push_rd", A_PUSH, 32'h0000_0000);
        wr(A_HEAD, 32'hFFFF_FFFF);
        rd("a_pop_head", A_HEAD, 32'h0000_0022);
        rd("a_pop_stat", A_STAT, 32'h0000_0200);
        rd("b_untouched", B_STAT, 32'h0000_0001);
        wr(A_HEAD, 32'd0);
        rd("a_pop2_head", A_HEAD, 32'h0000_0033);
        wr(A_HEAD, 32'd0);
        rd("a_drained", A_STAT, 32'h0000_0001);

        // Reserved register.
        wr(RSVD, 32'h1234_5678);
        rd("rsvd_rd", RSVD, 32'h0000_0000);

        // Fill and overflow B.
        for (int i = 0; i < 8; i++) wr(B_PUSH, 32'(i));
        rd("b_full_stat", B_STAT, 32'h0000_0802);
        wr(B_PUSH, 32'd8);
        rd("b_ovf_stat", B_STAT, 32'h0000_0806);
        for (int i = 0; i < 8; i++) begin
            rd($sformatf("b_pop%0d", i), B_HEAD, 32'(i));
            wr(B_HEAD, 32'd0);
        end
        rd("b_empty_ovf", B_STAT, 32'h0000_0005);
        rd("b_head_empty", B_HEAD, 32'h0000_0000);
        wr(B_STAT, 32'd0);
        rd("b_ovf_clr", B_STAT, 32'h0000_0001);

        // Wrap-around on A (read pointer currently at 3).
        for (int i = 0; i < 6; i++) wr(A_PUSH, 32'h50 + 32'(i));
        for (int i = 0; i < 6; i++) wr(A_HEAD, 32'd0);
        for (int i = 0; i < 6; i++) wr(A_PUSH, 32'hA0 + 32'(i));
        rd("wrap_stat", A_STAT, 32'h0000_0600);
        for (int i = 0; i < 6; i++) begin
            rd($sformatf("wrap_pop%0d", i), A_HEAD, 32'hA0 + 32'(i));
            wr(A_HEAD, 32'd0);
        end

        // Pop on empty A: no underflow.
        wr(A_HEAD, 32'd0);
        rd("a_uf_stat", A_STAT, 32'h0000_0001);
        rd("a_uf_head", A_HEAD, 32'h0000_0000);
        wr(A_PUSH, 32'h77);
        rd("a_after_uf", A_HEAD, 32'h0000_0077);
        wr(A_HEAD, 32'd0);

`ifdef CORE_MAILBOX_IRQ_EN
        wr(IRQ_EN, 32'hFFFF_FFFF);
        rd("irq_en_rd", IRQ_EN, 32'h0000_0003);
        check("irq_a_idle", {31'd0, irq_a_o}, 32'd0);
        wr(A_PUSH, 32'h99);
        check("irq_a_edge_n", {31'd0, irq_a_o}, 32'd0);
        idle_cycle();
        check("irq_a_n1", {31'd0, irq_a_o}, 32'd1);
        check("irq_b_quiet", {31'd0, irq_b_o}, 32'd0);
        wr(A_HEAD, 32'd0);
        check("irq_a_pop_m", {31'd0, irq_a_o}, 32'd1);
        idle_cycle();
        check("irq_a_pop_m1", {31'd0, irq_a_o}, 32'd0);
        wr(B_PUSH, 32'h5);
        idle_cycle();
        check("irq_b_set", {31'd0, irq_b_o}, 32'd1);
        wr(IRQ_EN, 32'h1);
        idle_cycle();
        check("irq_b_masked", {31'd0, irq_b_o}, 32'd0);
        wr(B_HEAD, 32'd0);
`else
        wr(IRQ_EN, 32'h0000_0003);
        rd("irq_en_rd0", IRQ_EN, 32'h0000_0000);
        wr(A_PUSH, 32'h99);
        idle_cycle();
        check("irq_a_off", {31'd0, irq_a_o}, 32'd0);
        idle_cycle();
        check("irq_a_off2", {31'd0, irq_a_o}, 32'd0);
        wr(A_HEAD, 32'd0);
`endif

        // Mid-stream reset discards queued entries.
        wr(A_PUSH, 32'hC0);
        wr(A_PUSH, 32'hC1);
        wr(B_PUSH, 32'hD0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd("mid_a_stat", A_STAT, 32'h0000_0001);
        rd("mid_b_stat", B_STAT, 32'h0000_0001);
        rd("mid_a_head", A_HEAD, 32'h0000_0000);
        rd("mid_irq_en", IRQ_EN, 32'h0000_0000);
        idle_cycle();
        check("mid_irq_a", {31'd0, irq_a_o}, 32'd0);
        check("mid_irq_b", {31'd0, irq_b_o}, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
